// File: rtl/ca_acq_sequencer_pkg.sv
// Shared definitions for the C/A acquisition sequencer.
package ca_pkg;

  localparam int unsigned SAT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_TRACK  = 2'd3
  } ca_state_t;

  // Next PRN select in the scan range; wraps from last back to first.
  function automatic logic [SAT_W-1:0] sat_advance(
    input logic [SAT_W-1:0] cur,
    input logic [SAT_W-1:0] first,
    input logic [SAT_W-1:0] last
  );
    return (cur == last) ? first : cur + 1'b1;
  endfunction

endpackage

// File: rtl/ca_acq_sequencer_edgetopulse.sv
// Rising-edge detector: registers the level once and compares it
// with the previous registered sample.
module edgetopulse (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic q;
  logic q_prev;

  // Sample the level and keep one cycle of history.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= 1'b0;
      q_prev <= 1'b0;
    end else begin
      q      <= din;
      q_prev <= q;
    end
  end

  assign pulse = q & ~q_prev;

endmodule

// File: rtl/ca_acq_sequencer.sv
// Acquisition/track sequencer: scans PRNs at slew rate, verifies a
// correlation hit at track rate, holds lock and falls back on loss.
module ca_acq_sequencer
  import ca_pkg::*;
#(
  parameter int unsigned SAT_FIRST     = 1,
  parameter int unsigned SAT_LAST      = 31,
  parameter int unsigned DWELL_EPOCHS  = 1023,
  parameter int unsigned VERIFY_EPOCHS = 16,
  parameter int unsigned VERIFY_HITS   = 12,
  parameter int unsigned LOSS_MISSES   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             hold,
  input  logic             epoch,
  input  logic             corr_hi,
  output logic [SAT_W-1:0] sat,
  output logic             codetrack,
  output logic             locked,
  output logic             sat_step,
  output logic [1:0]       state
);

  localparam int unsigned DW = (DWELL_EPOCHS > 1) ? $clog2(DWELL_EPOCHS) : 1;
  localparam int unsigned VW = $clog2(VERIFY_EPOCHS + 1);
  localparam int unsigned MW = $clog2(LOSS_MISSES + 1);

  localparam logic [DW-1:0]    DWELL_LAST  = DW'(DWELL_EPOCHS - 1);
  localparam logic [VW-1:0]    VERIFY_LAST = VW'(VERIFY_EPOCHS - 1);
  localparam logic [VW-1:0]    HITS_NEED   = VW'(VERIFY_HITS);
  localparam logic [MW-1:0]    MISS_LAST   = MW'(LOSS_MISSES - 1);
  localparam logic [SAT_W-1:0] SAT_LO      = SAT_W'(SAT_FIRST);
  localparam logic [SAT_W-1:0] SAT_HI      = SAT_W'(SAT_LAST);

  ca_state_t      st;
  logic [DW-1:0]  dwell;
  logic [VW-1:0]  vcnt;
  logic [VW-1:0]  hcnt;
  logic [MW-1:0]  miss;
  logic           corr_s1;
  logic           corr_s2;
  logic           epoch_edge;
  logic           hit;
  logic [VW-1:0]  hits_next;
  logic [SAT_W-1:0] sat_next;

  edgetopulse u_epoch_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (epoch),
    .pulse (epoch_edge)
  );

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge clk) begin
    if (rst) begin
      corr_s1 <= 1'b0;
      corr_s2 <= 1'b0;
    end else begin
      corr_s1 <= corr_hi;
      corr_s2 <= corr_s1;
    end
  end

  // Per-epoch derived values used by the state machine.
  always_comb begin
    hit       = corr_s2;
    hits_next = hcnt + VW'(hit);
    sat_next  = sat_advance(sat, SAT_LO, SAT_HI);
  end

  assign state = st;

  // Sequencer state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      sat       <= SAT_LO;
      codetrack <= 1'b0;
      locked    <= 1'b0;
      sat_step  <= 1'b0;
      dwell     <= '0;
      vcnt      <= '0;
      hcnt      <= '0;
      miss      <= '0;
    end else begin
      sat_step <= 1'b0;
      if (!enable) begin
        st        <= ST_IDLE;
        sat       <= SAT_LO;
        codetrack <= 1'b0;
        locked    <= 1'b0;
        sat_step  <= (sat != SAT_LO);
        dwell     <= '0;
        vcnt      <= '0;
        hcnt      <= '0;
        miss      <= '0;
      end else if (epoch_edge) begin
        case (st)
          // Leaving IDLE consumes the epoch; scanning starts on the next one.
          ST_IDLE: begin
            st <= ST_SEARCH;
          end
          ST_SEARCH: begin
            if (hit) begin
              st        <= ST_VERIFY;
              codetrack <= 1'b1;
              vcnt      <= '0;
              hcnt      <= '0;
            end else if (dwell == DWELL_LAST) begin
              dwell <= '0;
              if (!hold) begin
                sat      <= sat_next;
                sat_step <= 1'b1;
              end
            end else begin
              dwell <= dwell + 1'b1;
            end
          end
          ST_VERIFY: begin
            if (vcnt == VERIFY_LAST) begin
              vcnt <= '0;
              hcnt <= '0;
              miss <= '0;
              if (hits_next >= HITS_NEED) begin
                st     <= ST_TRACK;
                locked <= 1'b1;
              end else begin
                st        <= ST_SEARCH;
                codetrack <= 1'b0;
              end
            end else begin
              vcnt <= vcnt + 1'b1;
              hcnt <= hits_next;
            end
          end
          ST_TRACK: begin
            if (hit) begin
              miss <= '0;
            end else if (miss == MISS_LAST) begin
              st        <= ST_SEARCH;
              codetrack <= 1'b0;
              locked    <= 1'b0;
              dwell     <= '0;
              miss      <= '0;
            end else begin
              miss <= miss + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ca_acq_sequencer.sv
// Scoreboard bench for ca_acq_sequencer: stimulus pushes expected output
// changes from an epoch-level model; a monitor pops on every change.
module tb_ca_acq_sequencer;

  localparam int DWELL = 4;
  localparam int VE    = 4;
  localparam int VH    = 3;
  localparam int LM    = 2;
  localparam int SF    = 1;
  localparam int SL    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       hold = 1'b0;
  logic       epoch = 1'b0;
  logic       corr_hi = 1'b0;
  logic [4:0] sat;
  logic       codetrack;
  logic       locked;
  logic       sat_step;
  logic [1:0] state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int         t;
    logic [1:0] st;
    logic [4:0] sat;
    logic       ct;
    logic       lk;
    logic       step;
  } exp_t;

  exp_t q[$];

  // Reference model: mode 0 idle, 1 search, 2 verify, 3 track.
  int m_mode = 0, m_sat = SF, m_dwell = 0, m_v = 0, m_n = 0, m_miss = 0;
  int p_mode = 0, p_sat = SF;

  ca_acq_sequencer #(
    .SAT_FIRST    (SF),
    .SAT_LAST     (SL),
    .DWELL_EPOCHS (DWELL),
    .VERIFY_EPOCHS(VE),
    .VERIFY_HITS  (VH),
    .LOSS_MISSES  (LM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .hold     (hold),
    .epoch    (epoch),
    .corr_hi  (corr_hi),
    .sat      (sat),
    .codetrack(codetrack),
    .locked   (locked),
    .sat_step (sat_step),
    .state    (state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic emit(input int t, input bit step);
    exp_t e;
    if (step || m_mode != p_mode || m_sat != p_sat) begin
      e.t    = t;
      e.st   = 2'(m_mode);
      e.sat  = 5'(m_sat);
      e.ct   = (m_mode >= 2);
      e.lk   = (m_mode == 3);
      e.step = step;
      q.push_back(e);
    end
    p_mode = m_mode;
    p_sat  = m_sat;
  endtask

  task automatic model_clear(input int t, input bit allow_step);
    bit step;
    step    = allow_step && (m_sat != SF);
    m_mode  = 0;
    m_sat   = SF;
    m_dwell = 0;
    m_v     = 0;
    m_n     = 0;
    m_miss  = 0;
    emit(t, step);
  endtask

  task automatic model_epoch(input bit h, input bit hd, input int t);
    bit step;
    step = 1'b0;
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (h) begin
          m_mode = 2;
          m_v    = 0;
          m_n    = 0;
        end else begin
          m_dwell++;
          if (m_dwell == DWELL) begin
            m_dwell = 0;
            if (!hd) begin
              m_sat = (m_sat == SL) ? SF : m_sat + 1;
              step  = 1'b1;
            end
          end
        end
      end
      2: begin
        m_v++;
        m_n += int'(h);
        if (m_v == VE) begin
          m_mode = (m_n >= VH) ? 3 : 1;
          m_miss = 0;
        end
      end
      default: begin
        if (h) m_miss = 0;
        else begin
          m_miss++;
          if (m_miss == LM) begin
            m_mode  = 1;
            m_dwell = 0;
            m_miss  = 0;
          end
        end
      end
    endcase
    emit(t, step);
  endtask

  // One epoch: comparator and hold settle first, then a rising epoch level.
  // drop_en pulls enable low so it is sampled on the epoch decision clock.
  task automatic do_epoch(input bit h, input bit hd, input bit drop_en);
    int c0;
    corr_hi = h;
    hold    = hd;
    tick(2);
    epoch = 1'b1;
    c0    = cyc;
    if (drop_en) model_clear(c0 + 2, 1'b1);
    else         model_epoch(h, hd, c0 + 2);
    tick(1);
    if (drop_en) enable = 1'b0;
    tick(2);
    epoch  = 1'b0;
    enable = 1'b1;
    tick(2);
  endtask

  task automatic drop_enable();
    enable = 1'b0;
    model_clear(cyc + 1, 1'b1);
    tick(2);
    enable = 1'b1;
    tick(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear(cyc + 1, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Monitor: every output change (or sat_step high) consumes one expectation.
  initial begin
    logic [8:0] prev, cur;
    exp_t e;
    wait (mon_on);
    prev = {2'd0, 5'd1, 1'b0, 1'b0};
    forever begin
      @(negedge clk);
      cur = {state, sat, codetrack, locked};
      if (cur != prev || sat_step) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_change cyc=%0d got st=%0d sat=%0d ct=%0b lk=%0b step=%0b, required no change",
                   cyc, state, sat, codetrack, locked, sat_step);
        end else begin
          e = q.pop_front();
          if (e.t != cyc || e.st != state || e.sat != sat || e.ct != codetrack ||
              e.lk != locked || e.step != sat_step) begin
            miscompares++;
            $display("FAIL output_change got cyc=%0d st=%0d sat=%0d ct=%0b lk=%0b step=%0b required cyc=%0d st=%0d sat=%0d ct=%0b lk=%0b step=%0b",
                     cyc, state, sat, codetrack, locked, sat_step,
                     e.t, e.st, e.sat, e.ct, e.lk, e.step);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    int regime, pct;
    bit h, hd, dr;

    tick(3);
    @(negedge clk);
    vectors++;
    if (state !== 2'd0 || sat !== 5'd1 || codetrack !== 1'b0 || locked !== 1'b0 || sat_step !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values got st=%0d sat=%0d ct=%0b lk=%0b step=%0b required st=0 sat=1 ct=0 lk=0 step=0",
               state, sat, codetrack, locked, sat_step);
    end
    mon_on = 1'b1;
    tick(1);
    rst    = 1'b0;
    enable = 1'b1;
    tick(2);

    // Leave IDLE, then sweep 12 missed epochs: 1->2->3->1.
    do_epoch(0, 0, 0);
    for (int i = 0; i < 12; i++) do_epoch(0, 0, 0);

    // Acquire on sat 2 at its second epoch, 3 of 4 verify hits.
    for (int i = 0; i < 4; i++) do_epoch(0, 0, 0);
    do_epoch(0, 0, 0);
    do_epoch(1, 0, 0);
    do_epoch(1, 0, 0);
    do_epoch(1, 0, 0);
    do_epoch(0, 0, 0);
    do_epoch(1, 0, 0);

    // Loss of lock: miss, hit, miss, miss.
    do_epoch(0, 0, 0);
    do_epoch(1, 0, 0);
    do_epoch(0, 0, 0);
    do_epoch(0, 0, 0);

    // Failed verify with dwell preserved at 2, then 2 misses advance sat.
    do_epoch(0, 0, 0);
    do_epoch(0, 0, 0);
    do_epoch(1, 0, 0);
    do_epoch(1, 0, 0);
    do_epoch(0, 0, 0);
    do_epoch(1, 0, 0);
    do_epoch(0, 0, 0);
    do_epoch(0, 0, 0);
    do_epoch(0, 0, 0);

    // Hold through two dwell wraps, then release.
    for (int i = 0; i < 8; i++) do_epoch(0, 1, 0);
    for (int i = 0; i < 4; i++) do_epoch(0, 0, 0);

    // Reach TRACK on sat 3, then disable on a hit epoch.
    for (int i = 0; i < 40 && m_sat != 3; i++) do_epoch(0, 0, 0);
    for (int i = 0; i < 5; i++) do_epoch(1, 0, 0);
    do_epoch(1, 0, 1);

    // Back to SEARCH, then reset mid-search.
    do_epoch(0, 0, 0);
    do_epoch(0, 0, 0);
    do_reset();

    // Randomized regimes of mostly-miss, mostly-hit and mixed epochs.
    regime = 0;
    for (int i = 0; i < 260; i++) begin
      if (i % 8 == 0) regime = $urandom_range(0, 2);
      pct = (regime == 0) ? 10 : (regime == 1) ? 88 : 50;
      h   = ($urandom_range(0, 99) < pct);
      hd  = ($urandom_range(0, 99) < 15);
      dr  = ($urandom_range(0, 99) < 3);
      do_epoch(h, hd, dr);
      if ($urandom_range(0, 99) < 3) drop_enable();
      if ($urandom_range(0, 149) == 0) do_reset();
    end

    tick(6);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_expectations got %0d outstanding required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ca_acq_sequencer.md
# ca_acq_sequencer

Acquisition/track sequencer for the C/A code tracker. Steps the 5-bit satellite select through a PRN range while the tracker slews at scan rate. It also switches the tracker to track rate on a correlation hit, verifies the hit over a fixed epoch window, and declares lock. On loss of lock it falls back to search. It sits between the analog correlator comparator and the tracker's `sat`/`codetrack` inputs, and is clocked by the tracker's `epoch` output.

## Interface
- `SAT_FIRST`, default 1: first PRN select value.
- `SAT_LAST`, default 31: last PRN select value; must be ≥ `SAT_FIRST`.
- `DWELL_EPOCHS`, default 1023: epochs searched per satellite before advancing.
- `VERIFY_EPOCHS`, default 16: length of the verify window in epochs.
- `VERIFY_HITS`, default 12: hits within the window required to declare lock.
- `LOSS_MISSES`, default 8: consecutive missed epochs in TRACK that declare loss.
- `clk`  in  1  system clock (single clock domain).
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  run sequencer; low forces IDLE.
- `hold`  in  1  inhibit satellite advance; dwell still counts and wraps.
- `epoch`  in  1  tracker code-epoch level (1 ms period); rising edge is the event.
- `corr_hi`  in  1  asynchronous correlator comparator, high = correlation above threshold.
- `sat`  out  5  PRN select to tracker.
- `codetrack`  out  1  to tracker; 0 = 64k scan slew, 1 = 32k track loop.
- `locked`  out  1  high only in TRACK.
- `sat_step`  out  1  one-clock pulse when `sat` changes.
- `state`  out  2  current state code, for debug.

## Operation
- `corr_hi` passes through a 2-FF synchronizer before use.
- A hit is the synchronized `corr_hi` sampled high on the epoch-edge cycle; a miss is the same sample low.
- All counters and state advance only on epoch-edge cycles, except the IDLE entry.
- **IDLE (0)**
  - `codetrack` = 0, `locked` = 0, `sat` = `SAT_FIRST`; dwell, verify and miss counters cleared.
  - `enable` high → SEARCH.
- **SEARCH (1)**
  - `codetrack` = 0.
  - Hit → VERIFY; verify epoch counter and hit counter cleared. The dwell counter is preserved.
  - Miss → dwell + 1.
  - When dwell reaches `DWELL_EPOCHS`−1 on a miss, dwell → 0 and, if `hold` = 0, `sat` advances.
  - `sat` advances by +1 and wraps from `SAT_LAST` to `SAT_FIRST`; `sat_step` pulses on every advance.
- **VERIFY (2)**
  - `codetrack` = 1.
  - Each epoch increments the verify epoch counter; a hit also increments the hit counter.
  - After `VERIFY_EPOCHS` epochs, counting the current one:
    - hits ≥ `VERIFY_HITS` → TRACK;
    - otherwise → SEARCH, same `sat`, dwell resumed from its preserved value.
- **TRACK (3)**
  - `codetrack` = 1, `locked` = 1.
  - Hit → miss counter cleared. Miss → miss counter + 1.
  - Miss counter reaching `LOSS_MISSES` → SEARCH, same `sat`, dwell = 0.
- **Precedence, highest first:** `rst` > `enable` low (→ IDLE, from any state) > epoch-driven transition.
- **IDLE entry sat_step:** returning to IDLE with `sat` ≠ `SAT_FIRST` pulses `sat_step` once.
- **`hold` during dwell wrap:** dwell wraps to 0, `sat` is unchanged, no `sat_step`.
- **Single satellite:** with `SAT_FIRST` = `SAT_LAST`, an advance leaves `sat` unchanged and `sat_step` still pulses.
- **Counter widths:**
  - dwell: $clog2(`DWELL_EPOCHS`);
  - verify epoch and hit counters: $clog2(`VERIFY_EPOCHS`+1);
  - miss counter: $clog2(`LOSS_MISSES`+1).
  - No counter saturates or overflows beyond its terminal value.

## Timing
- Reset values: state = IDLE, `sat` = `SAT_FIRST`, `codetrack` = 0, `locked` = 0, `sat_step` = 0, `state` = 0.
- The epoch edge cycle is the first clock on which registered `epoch` = 1 and the previous sample was 0.
- Edge-cycle decision latency: all outputs update on the clock edge ending the epoch-edge cycle.
- `corr_hi` latency: the value used at an epoch is `corr_hi` as it was 2 clocks before the edge cycle.
- `enable` low: IDLE and its outputs take effect one clock after `enable` is sampled low.
- `sat_step` is asserted in the same cycle `sat` takes its new value, for exactly one clock.
- Every output is registered; no combinational path from an input to an output.

## Structure
- Shared package `ca_pkg`:
  - state encoding constants `ST_IDLE`, `ST_SEARCH`, `ST_VERIFY`, `ST_TRACK` (2 bits);
  - `SAT_W` = 5.
- The epoch edge uses the existing `edgetopulse` sub-module instance; no other sub-module.
- The synchronizer is two registers inline.

## Test plan
Parameters for all scenarios: `DWELL_EPOCHS` = 4, `VERIFY_EPOCHS` = 4, `VERIFY_HITS` = 3, `LOSS_MISSES` = 2, `SAT_FIRST` = 1, `SAT_LAST` = 3.
- **Sweep and wrap:** `corr_hi` = 0 for 12 epochs → `sat` goes 1→2→3→1, once every 4 epochs, with one `sat_step` per change; `codetrack` stays 0.
- **Acquire:** `corr_hi` = 1 at epoch 2 of sat 2, then hits on 3 of the next 4 epochs → VERIFY with `codetrack` = 1, then TRACK with `locked` = 1, `sat` = 2.
- **Failed verify:** only 2 hits in the 4-epoch window → SEARCH, `sat` unchanged, `codetrack` = 0. The dwell count resumes, so `sat` advances after the remaining 2 missed epochs.
- **Loss of lock:** in TRACK, pattern miss, hit, miss, miss → `locked` stays 1 through the first miss and drops after the second consecutive miss; SEARCH, dwell = 0.
- **Hold:** `hold` = 1 during 8 missed epochs → `sat` constant and no `sat_step`; releasing `hold` → advance after 4 more misses.
- **Disable mid-track, then reset:** `enable` → 0 on an epoch-edge cycle with a hit in TRACK at `sat` = 3 → IDLE next clock, `sat` = 1, one `sat_step`, `locked` = 0. Then `rst` pulsed mid-SEARCH → all reset values the next clock.
